// File: rtl/fxp_pkg.sv
// Shared fixed-point datapath package: default widths, divider FSM states
// and the saturation constant. Used by fxp_div, fxp_sat and fxp_mul.
package fxp_pkg;

    localparam int FXP_WIDTH = 32;
    localparam int FXP_FRAC  = 16;

    // All-ones value that a saturated result takes at the default width.
    localparam logic [FXP_WIDTH-1:0] FXP_SAT_ONES = {FXP_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fxp_state_e;

endpackage : fxp_pkg

// File: rtl/fxp_sat.sv
// Combinational saturation of a (WIDTH+FRAC)-bit unsigned value down to
// WIDTH bits. Any set bit above the result width clamps to all-ones and
// raises ovf.
module fxp_sat
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH,
    parameter int FRAC  = FXP_FRAC
) (
    input  logic [WIDTH+FRAC-1:0] val,
    output logic [WIDTH-1:0]      res,
    output logic                  ovf
);

    // Clamp when the value does not fit in WIDTH bits.
    always_comb begin
        res = {WIDTH{1'b0}};
        ovf = 1'b0;
        if (|val[WIDTH+FRAC-1:WIDTH]) begin
            res = {WIDTH{1'b1}};
            ovf = 1'b1;
        end else begin
            res = val[WIDTH-1:0];
            ovf = 1'b0;
        end
    end

endmodule : fxp_sat

// File: rtl/fxp_div.sv
// Sequential unsigned fixed-point divider: c = (a << FRAC) / b by restoring
// long division, one quotient bit per clock, with saturation on overflow and
// on divide-by-zero. Valid/ready handshakes on operands and result.
// Optional feature macro: FXP_DIV_ROUND_EN (round to nearest, ties up);
// without it the quotient is truncated toward zero.
module fxp_div
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH,
    parameter int FRAC  = FXP_FRAC
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] c_o,
    output logic             dz_o,
    output logic             ovf_o
);

    localparam int WF    = WIDTH + FRAC;
    localparam int CNT_W = $clog2(WF);

    // The dividend register doubles as the quotient register: its MSB feeds
    // the remainder while quotient bits enter at the LSB, so after WF steps
    // it holds the full quotient.
    fxp_state_e       state_r, state_s;
    logic [WF-1:0]    dvd_r, dvd_s;
    logic [WIDTH-1:0] rem_r, rem_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             dzp_r, dzp_s;
    logic [WIDTH-1:0] c_r, c_s;
    logic             dz_r, dz_s;
    logic             ovf_r, ovf_s;
    logic             out_valid_r, out_valid_s;
    logic             in_ready_r, in_ready_s;

    // One division step on the current registers.
    logic [WIDTH:0]   rem_sh_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic [WF-1:0]    quo_nx_s;
    logic             rnd_s;
    logic [WF:0]      quo_rnd_s;
    logic [WIDTH-1:0] sat_res_s;
    logic             sat_ovf_s;

    // Restoring step, final rounding decision and the rounded quotient.
    always_comb begin
        rem_sh_s = {rem_r, dvd_r[WF-1]};
        ge_s     = (rem_sh_s >= {1'b0, b_r});
        if (ge_s) begin
            rem_nx_s = WIDTH'(rem_sh_s - {1'b0, b_r});
        end else begin
            rem_nx_s = rem_sh_s[WIDTH-1:0];
        end
        quo_nx_s = {dvd_r[WF-2:0], ge_s};
`ifdef FXP_DIV_ROUND_EN
        rnd_s = ({rem_nx_s, 1'b0} >= {1'b0, b_r});
`else
        rnd_s = 1'b0;
`endif
        quo_rnd_s = {1'b0, quo_nx_s} + {{WF{1'b0}}, rnd_s};
    end

    fxp_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_sat (
        .val (quo_rnd_s[WF-1:0]),
        .res (sat_res_s),
        .ovf (sat_ovf_s)
    );

    // State register and all datapath/output registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r     <= IDLE;
            dvd_r       <= {WF{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            dzp_r       <= 1'b0;
            c_r         <= {WIDTH{1'b0}};
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            dvd_r       <= dvd_s;
            rem_r       <= rem_s;
            b_r         <= b_s;
            cnt_r       <= cnt_s;
            dzp_r       <= dzp_s;
            c_r         <= c_s;
            dz_r        <= dz_s;
            ovf_r       <= ovf_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
        end
    end

    // Next-state and next-register values for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_s     = state_r;
        dvd_s       = dvd_r;
        rem_s       = rem_r;
        b_s         = b_r;
        cnt_s       = cnt_r;
        dzp_s       = dzp_r;
        c_s         = c_r;
        dz_s        = dz_r;
        ovf_s       = ovf_r;
        out_valid_s = out_valid_r;
        in_ready_s  = in_ready_r;
        case (state_r)
            IDLE: begin
                if (in_valid_i) begin
                    b_s        = b_i;
                    in_ready_s = 1'b0;
                    state_s    = CALC;
                    if (b_i == {WIDTH{1'b0}}) begin
                        // A zero divisor spends a single CALC cycle so its
                        // saturated result appears one edge after accept.
                        dzp_s = 1'b1;
                        cnt_s = {CNT_W{1'b0}};
                    end else begin
                        dzp_s = 1'b0;
                        dvd_s = {a_i, {FRAC{1'b0}}};
                        rem_s = {WIDTH{1'b0}};
                        cnt_s = CNT_W'(WF - 1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (dzp_r) begin
                    state_s     = DONE;
                    c_s         = {WIDTH{1'b1}};
                    dz_s        = 1'b1;
                    ovf_s       = 1'b0;
                    out_valid_s = 1'b1;
                end else begin
                    dvd_s = quo_nx_s;
                    rem_s = rem_nx_s;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_s     = DONE;
                        c_s         = sat_res_s;
                        dz_s        = 1'b0;
                        ovf_s       = sat_ovf_s | quo_rnd_s[WF];
                        out_valid_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                out_valid_s = 1'b0;
                in_ready_s  = 1'b1;
            end
        endcase
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign c_o         = c_r;
    assign dz_o        = dz_r;
    assign ovf_o       = ovf_r;

endmodule : fxp_div

// File: doc/fxp_div.md
# fxp_div

Sequential unsigned fixed-point divider, the inverse of the fixed-point multiplier in the softmax datapath. It computes q = (a << FRAC) / b by restoring long division, one quotient bit per clock. It sits after the exponent-sum accumulator and produces each softmax output as exp(x_i) / Σexp. Operands and results use valid/ready handshakes with saturation on overflow and on divide-by-zero.

## Interface
- WIDTH, 32: operand and result width, in bits.
- FRAC, 16: number of fractional bits (Q(WIDTH-FRAC).FRAC).
- clk_i  input  1  clock; all logic on the rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  divider can accept operands.
- a_i  input  WIDTH  dividend, unsigned fixed-point.
- b_i  input  WIDTH  divisor, unsigned fixed-point.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- c_o  output  WIDTH  quotient, unsigned fixed-point.
- dz_o  output  1  divide-by-zero flag, qualified by out_valid_o.
- ovf_o  output  1  overflow/saturation flag, qualified by out_valid_o.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i: latch the operands.
  - If b_i==0: go to DONE with c=all-ones, dz=1.
  - Otherwise: load the dividend register with a_i<<FRAC (WIDTH+FRAC bits), clear the remainder, set cnt=WIDTH+FRAC-1, go to CALC.
- CALC, one step per cycle:
  - rem' = {rem, next dividend MSB}.
  - If rem' ≥ b: subtract b and shift in quotient bit 1; else shift in 0.
  - When cnt==0: go to DONE; otherwise decrement cnt.
  - in_ready_o=0.
- Result: the full quotient is WIDTH+FRAC bits wide. If any of its upper FRAC bits is set: c_o=all-ones, ovf_o=1. Otherwise c_o = low WIDTH bits.
- DONE:
  - out_valid_o=1; c_o, dz_o and ovf_o are held stable.
  - On out_ready_i: go to IDLE.
  - If out_ready_i stays low: hold indefinitely.
- No operand acceptance in CALC or DONE.
- Unsigned only; a_i=0 with b≠0 yields 0 after the full latency.

## Timing
- Reset values: in_ready_o=1 (takes effect on the first clock with rst_n_i low); out_valid_o=0, c_o=0, dz_o=0, ovf_o=0.
- Let accept edge = T.
  - Normal divide: out_valid_o high from edge T+WIDTH+FRAC (T+48 at defaults).
  - Divide-by-zero: out_valid_o high from edge T+1.
- Result handshake on edge U moves to IDLE. Earliest next accept is edge U+1, so throughput is one divide per WIDTH+FRAC+2 cycles.
- rst_n_i low in any state, including mid-CALC: on the next edge go to IDLE, clear all outputs and flags, and discard the operation.
- in_valid_i asserted outside IDLE is ignored and not queued.
- out_ready_i asserted while out_valid_o=0 has no effect.

## Configuration
- FXP_DIV_ROUND_EN defined:
  - Round to nearest, ties up: add 1 to the quotient when 2·rem ≥ b after the last step.
  - An increment that overflows WIDTH saturates and sets ovf_o.
  - Latency is unchanged; the rounding is combinational in DONE entry.
- FXP_DIV_ROUND_EN undefined: the quotient is truncated toward zero.

## Structure
- Shared package fxp_pkg: default WIDTH/FRAC constants, the FSM state typedef (IDLE/CALC/DONE), and the all-ones saturation constant. fxp_mul shares the same package.
- Sub-module fxp_sat: combinational saturation of a (WIDTH+FRAC)-bit value to WIDTH bits, producing an ovf flag. It is reused by fxp_mul. All other logic lives in fxp_div.

## Test plan
- a=0x0001_0000 (1.0), b=0x0004_0000 (4.0) -> c_o=0x0000_4000, dz=0, ovf=0; out_valid_o rises exactly 48 cycles after accept.
- a=0x0002_0000, b=0x0003_0000 -> c_o=0x0000_AAAA without the macro, 0x0000_AAAB with FXP_DIV_ROUND_EN.
- a=0x8000_0000, b=0x0000_8000 -> c_o=0xFFFF_FFFF, ovf_o=1.
- a=0x1234_5678, b=0 -> out_valid_o at accept+1, c_o=0xFFFF_FFFF, dz_o=1; in_ready_o low until the result handshake.
- out_ready_i held low for 10 cycles in DONE -> outputs stable, in_ready_o=0, extra in_valid_i pulses ignored; a second divide then completes correctly.
- rst_n_i low for one cycle at accept+20 -> next edge IDLE, out_valid_o never asserts; a new divide of 3.0/2.0 returns 0x0001_8000.
